// File: rtl/if_stage.sv
// if_stage: instruction fetch with request/ready imem port, hazard hold and branch redirect.
// Define IF_STAGE_PERF_EN to add saturating stall/flush performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcHOLD,
    input  logic        BranchControlSignal,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [63:0] IFIDReg
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [63:0] BUBBLE = {NOP_INSTR, 32'h0};
    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pending_target;
    logic [31:0] target;
    logic        take;
    assign target    = BranchTarget & ~32'h3;
    assign imem_req  = state != IDLE;
    // pc only advances on a ready cycle, so it doubles as the outstanding address in DRAIN
    assign imem_addr = pc;
    assign take      = imem_req && !pcHOLD && BranchControlSignal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            pending_target <= 32'h0;
            IFIDReg        <= BUBBLE;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (!pcHOLD) begin
                        if (BranchControlSignal) begin
                            IFIDReg <= BUBBLE;
                            if (imem_ready) begin
                                pc <= target;
                            end else begin
                                pending_target <= target;
                                state          <= DRAIN;
                            end
                        end else if (imem_ready) begin
                            IFIDReg <= {imem_rdata, pc + 32'd4};
                            pc      <= pc + 32'd4;
                        end else begin
                            IFIDReg <= BUBBLE;
                        end
                    end
                end
                DRAIN: begin
                    if (!pcHOLD) IFIDReg <= BUBBLE;
                    if (take) pending_target <= target;
                    // a redirect arriving with the discarded response still wins
                    if (imem_ready) begin
                        pc    <= take ? target : pending_target;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (imem_req && !imem_ready && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (take && ~&perf_flush_cnt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule
